hazard_controller: RTL

- Central control block that drives the stall/flush/nop inputs of the four pipeline registers (if_id, id_ex, ex_mem, mem_wb) and the PC stall.
- Detects load-use hazards, branch mispredicts and data-memory wait states.
- Provides an external halt/drain handshake and counts stall and flush events for performance monitoring.

---
 rtl/hazard_controller_pkg.sv | 29 ++
 rtl/hazard_controller_sat_counter.sv | 23 ++
 rtl/hazard_controller.sv | 171 +++++++++++++++++
 3 files changed

// File: rtl/hazard_controller_pkg.sv
// Shared types for the hazard controller: FSM state encoding and the per-stage
// pipeline-register control bundle.
`ifndef NUM_REGISTERS_LOG2
`define NUM_REGISTERS_LOG2 5
`endif

package hazard_controller_pkg;

  localparam int HZ_REG_BITS = `NUM_REGISTERS_LOG2;

  typedef enum logic [1:0] {
    HZ_RUN,
    HZ_MEM_WAIT,
    HZ_DRAIN,
    HZ_HALTED
  } hz_state_e;

  // Bundle order for one pipeline register: {stall, flush, nop}.
  localparam int PIPE_CTRL_BITS = 3;

  typedef struct packed {
    logic stall;
    logic flush;
    logic nop;
  } pipe_ctrl_t;

  localparam pipe_ctrl_t CTRL_IDLE = '{stall: 1'b0, flush: 1'b0, nop: 1'b0};

endpackage

// File: rtl/hazard_controller_sat_counter.sv
// Up-counter that sticks at MAX; a synchronous clear takes priority over enable.
module sat_counter #(
  parameter int               WIDTH = 32,
  parameter logic [WIDTH-1:0] MAX   = {WIDTH{1'b1}}
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             clear,
  input  logic             en,
  output logic [WIDTH-1:0] count
);

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      count <= '0;
    end else if (clear) begin
      count <= '0;
    end else if (en && (count != MAX)) begin
      count <= count + 1'b1;
    end
  end

endmodule

// File: rtl/hazard_controller.sv
// Pipeline hazard controller: load-use, mispredict and memory-wait handling,
// plus halt/drain handshake and saturating performance counters.
module hazard_controller
  import hazard_controller_pkg::*;
#(
  parameter int REG_BITS     = `NUM_REGISTERS_LOG2,
  parameter int DRAIN_CYCLES = 4,
  parameter int MEM_TIMEOUT  = 255,
  parameter int CNT_BITS     = 32
) (
  input  logic                clk,
  input  logic                reset,
  input  logic [REG_BITS-1:0] id_rs,
  input  logic [REG_BITS-1:0] id_rt,
  input  logic                id_uses_rt,
  input  logic                ex_mem_to_reg,
  input  logic [REG_BITS-1:0] ex_reg_dst,
  input  logic                ex_mispredict,
  input  logic                mem_busy,
  input  logic                halt_req,
  output logic                pc_stall,
  output logic                pc_redirect,
  output logic                if_id_stall,
  output logic                if_id_flush,
  output logic                if_id_nop,
  output logic                id_ex_stall,
  output logic                id_ex_flush,
  output logic                id_ex_nop,
  output logic                ex_mem_stall,
  output logic                ex_mem_flush,
  output logic                ex_mem_nop,
  output logic                mem_wb_stall,
  output logic                mem_wb_flush,
  output logic                mem_wb_nop,
  output logic                halted,
  output logic                mem_timeout_err,
  output logic [CNT_BITS-1:0] stall_count,
  output logic [CNT_BITS-1:0] flush_count
);

  localparam int TO_BITS = $clog2(MEM_TIMEOUT + 1);
  localparam int DR_BITS = $clog2(DRAIN_CYCLES + 1);
  localparam logic [TO_BITS-1:0] TO_MAX    = TO_BITS'(MEM_TIMEOUT);
  localparam logic [TO_BITS-1:0] TO_ARM    = TO_BITS'(MEM_TIMEOUT - 1);
  localparam logic [DR_BITS-1:0] DRAIN_END = DR_BITS'(DRAIN_CYCLES - 1);

  hz_state_e          state;
  logic [DR_BITS-1:0] drain_cnt;
  logic [TO_BITS-1:0] wait_cnt;
  logic               load_use;
  pipe_ctrl_t         if_id, id_ex, ex_mem, mem_wb;

  // Register 0 is hardwired, so a load targeting it never creates a dependency.
  assign load_use = ex_mem_to_reg && (ex_reg_dst != '0) &&
                    ((ex_reg_dst == id_rs) || (id_uses_rt && (ex_reg_dst == id_rt)));

  always_comb begin
    pc_stall    = 1'b0;
    pc_redirect = 1'b0;
    if_id       = CTRL_IDLE;
    id_ex       = CTRL_IDLE;
    ex_mem      = CTRL_IDLE;
    mem_wb      = CTRL_IDLE;
    if (reset) begin
      pc_stall     = 1'b1;
      if_id.flush  = 1'b1;
      id_ex.flush  = 1'b1;
      ex_mem.flush = 1'b1;
      mem_wb.flush = 1'b1;
    end else if (state == HZ_HALTED) begin
      pc_stall   = 1'b1;
      if_id.nop  = 1'b1;
      id_ex.nop  = 1'b1;
      ex_mem.nop = 1'b1;
      mem_wb.nop = 1'b1;
    end else if (mem_busy) begin
      // Holding ID/EX keeps any pending mispredict alive until memory completes.
      pc_stall     = 1'b1;
      if_id.stall  = 1'b1;
      id_ex.stall  = 1'b1;
      ex_mem.stall = 1'b1;
      mem_wb.flush = 1'b1;
    end else if (ex_mispredict) begin
      pc_redirect = 1'b1;
      pc_stall    = (state == HZ_DRAIN);
      if_id.flush = 1'b1;
      id_ex.flush = 1'b1;
    end else if (state == HZ_DRAIN) begin
      pc_stall    = 1'b1;
      if_id.flush = 1'b1;
    end else if (load_use) begin
      pc_stall    = 1'b1;
      if_id.stall = 1'b1;
      id_ex.flush = 1'b1;
    end
  end

  assign {if_id_stall,  if_id_flush,  if_id_nop}  = if_id;
  assign {id_ex_stall,  id_ex_flush,  id_ex_nop}  = id_ex;
  assign {ex_mem_stall, ex_mem_flush, ex_mem_nop} = ex_mem;
  assign {mem_wb_stall, mem_wb_flush, mem_wb_nop} = mem_wb;
  assign halted = (state == HZ_HALTED);

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state           <= HZ_RUN;
      drain_cnt       <= '0;
      mem_timeout_err <= 1'b0;
    end else begin
      if (mem_busy && (wait_cnt >= TO_ARM)) begin
        mem_timeout_err <= 1'b1;
      end
      case (state)
        HZ_RUN: begin
          if (mem_busy) begin
            state <= HZ_MEM_WAIT;
          end else if (halt_req) begin
            state     <= HZ_DRAIN;
            drain_cnt <= '0;
          end
        end
        HZ_MEM_WAIT: begin
          if (!mem_busy) begin
            state <= HZ_RUN;
          end
        end
        HZ_DRAIN: begin
          // A busy memory freezes the drain count; it resumes once the access completes.
          if (!mem_busy) begin
            if (drain_cnt == DRAIN_END) begin
              state <= HZ_HALTED;
            end else begin
              drain_cnt <= drain_cnt + 1'b1;
            end
          end
        end
        HZ_HALTED: begin
          if (!halt_req) begin
            state <= HZ_RUN;
          end
        end
        default: state <= HZ_RUN;
      endcase
    end
  end

  sat_counter #(.WIDTH(CNT_BITS)) u_stall_count (
    .clk   (clk),
    .reset (reset),
    .clear (1'b0),
    .en    (pc_stall),
    .count (stall_count)
  );

  sat_counter #(.WIDTH(CNT_BITS)) u_flush_count (
    .clk   (clk),
    .reset (reset),
    .clear (1'b0),
    .en    (pc_redirect),
    .count (flush_count)
  );

  sat_counter #(.WIDTH(TO_BITS), .MAX(TO_MAX)) u_wait_count (
    .clk   (clk),
    .reset (reset),
    .clear (!mem_busy),
    .en    (mem_busy),
    .count (wait_cnt)
  );

endmodule
